// File: rtl/spi_slave_wb_master.sv
// rtl/spi_slave_wb_master.sv - SPI mode-0 slave decoding a byte command stream into Wishbone master cycles
// Optional status bytes on miso during CMD/ADDR/read dummy: define SPI_SLAVE_STATUS_EN.
module spi_slave_wb_master #(
  parameter int ADDR_BITS  = 8,
  parameter int WB_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 sck,
  input  logic                 ss,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [ADDR_BITS-1:0] m_wb_addr,
  output logic [7:0]           m_wb_dat_m2s,
  input  logic [7:0]           m_wb_dat_s2m,
  output logic                 m_wb_we,
  output logic                 m_wb_sel,
  output logic                 m_wb_stb,
  output logic                 m_wb_cyc,
  input  logic                 m_wb_ack,
  input  logic                 m_wb_stall,
  output logic                 err
);
  localparam int TW = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [1:0] {F_IDLE, F_CMD, F_ADDR, F_DATA} f_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_ACK} w_state_t;

  f_state_t f_state, f_next;
  w_state_t w_state, w_next;

  logic [1:0]           sck_sync, ss_sync, mosi_sync;
  logic                 sck_d, sck_s, ss_s, mosi_s, sck_rise, sck_fall;
  logic [2:0]           bit_cnt;
  logic [6:0]           rx;
  logic [7:0]           rx_byte, tx, rd_data, status;
  logic                 is_rd, rd_valid, cur_keep;
  logic [ADDR_BITS-1:0] addr, addr_inc, addr_byte, req_addr;
  logic                 req_pend, req_we;
  logic [7:0]           req_dat;
  logic [TW-1:0]        tmo;
  logic active, frame_start, frame_end, byte_done, wb_free;
  logic rd_ovr, wr_ovr, launch, wb_done, tmo_hit;

  // ss synchroniser resets high so a reset never looks like a frame start
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_d     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[1];
  assign ss_s     = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign active      = (f_state != F_IDLE) && !ss_s;
  assign frame_start = (f_state == F_IDLE) && !ss_s;
  assign frame_end   = (f_state != F_IDLE) && ss_s;
  assign byte_done   = active && sck_rise && (bit_cnt == 3'd7);
  assign rx_byte     = {rx, mosi_s};
  assign addr_inc    = addr + ADDR_BITS'(1);
  assign wb_free     = (w_state == W_IDLE) && !req_pend;
  assign rd_ovr      = byte_done && (f_state == F_DATA) && is_rd && !rd_valid;
  assign wr_ovr      = byte_done && (f_state == F_DATA) && !is_rd && !wb_free;
  assign launch      = (w_state == W_IDLE) && req_pend;
  assign wb_done     = ((w_state == W_REQ) && !m_wb_stall && m_wb_ack) || ((w_state == W_ACK) && m_wb_ack);
  assign tmo_hit     = (w_state != W_IDLE) && !wb_done && (tmo == TW'(WB_TIMEOUT - 1));

  generate
    if (ADDR_BITS > 8) begin : g_addr_wide
      assign addr_byte = {{(ADDR_BITS - 8){1'b0}}, rx_byte};
    end else begin : g_addr_narrow
      assign addr_byte = rx_byte[ADDR_BITS-1:0];
    end
  endgenerate

`ifdef SPI_SLAVE_STATUS_EN
  logic sticky_ovr, sticky_tmo;

  // Cleared on the same edge the CMD byte captures them
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sticky_ovr <= 1'b0;
      sticky_tmo <= 1'b0;
    end else begin
      if (frame_start) begin
        sticky_ovr <= 1'b0;
        sticky_tmo <= 1'b0;
      end
      if (rd_ovr || wr_ovr) sticky_ovr <= 1'b1;
      if (tmo_hit) sticky_tmo <= 1'b1;
    end
  end

  assign status = {sticky_ovr, sticky_tmo, 6'b0};
`else
  assign status = 8'h00;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      f_state <= F_IDLE;
      w_state <= W_IDLE;
    end else begin
      f_state <= f_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE:  if (!ss_s) f_next = F_CMD;
      F_CMD:   if (byte_done) f_next = F_ADDR;
      F_ADDR:  if (byte_done) f_next = F_DATA;
      default: ;
    endcase
    if (ss_s) f_next = F_IDLE;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (req_pend) w_next = W_REQ;
      W_REQ:   if (wb_done || tmo_hit) w_next = W_IDLE;
               else if (!m_wb_stall) w_next = W_ACK;
      W_ACK:   if (wb_done || tmo_hit) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt      <= '0;
      rx           <= '0;
      tx           <= '0;
      is_rd        <= 1'b0;
      addr         <= '0;
      req_pend     <= 1'b0;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_dat      <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      cur_keep     <= 1'b0;
      tmo          <= '0;
      m_wb_addr    <= '0;
      m_wb_dat_m2s <= '0;
      m_wb_we      <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= rd_ovr | wr_ovr | tmo_hit;
      tmo <= (w_state == W_IDLE) ? '0 : tmo + TW'(1);
      if (launch) begin
        m_wb_addr    <= req_addr;
        m_wb_dat_m2s <= req_dat;
        m_wb_we      <= req_we;
        req_pend     <= 1'b0;
        cur_keep     <= 1'b1;
      end
      if ((wb_done || tmo_hit) && !m_wb_we && cur_keep) begin
        rd_data  <= wb_done ? m_wb_dat_s2m : 8'hFF;
        rd_valid <= 1'b1;
      end
      if (frame_start) begin
        tx      <= status;
        bit_cnt <= '0;
      end
      // Anything still in flight when the frame closes belongs to nobody
      if (frame_end) begin
        bit_cnt  <= '0;
        req_pend <= 1'b0;
        rd_valid <= 1'b0;
        cur_keep <= 1'b0;
      end
      if (active) begin
        // Skip the shift right after a byte boundary so the reloaded bit7 stays on miso
        if (sck_fall && bit_cnt != 3'd0) tx <= {tx[6:0], 1'b0};
        if (sck_rise) begin
          rx      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (f_state)
            F_CMD: begin
              is_rd <= rx_byte[7];
              tx    <= status;
            end
            F_ADDR: begin
              addr <= addr_byte;
              tx   <= is_rd ? status : 8'h00;
              if (is_rd) begin
                req_pend <= 1'b1;
                req_we   <= 1'b0;
                req_addr <= addr_byte;
              end
            end
            F_DATA: begin
              if (is_rd) begin
                tx       <= rd_valid ? rd_data : 8'hFF;
                rd_valid <= 1'b0;
                if (!rd_valid) cur_keep <= 1'b0;
                req_pend <= 1'b1;
                req_we   <= 1'b0;
                req_addr <= addr_inc;
                addr     <= addr_inc;
              end else begin
                tx <= 8'h00;
                if (wb_free) begin
                  req_pend <= 1'b1;
                  req_we   <= 1'b1;
                  req_addr <= addr;
                  req_dat  <= rx_byte;
                  addr     <= addr_inc;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign m_wb_cyc = (w_state != W_IDLE);
  assign m_wb_stb = (w_state == W_REQ);
  assign m_wb_sel = m_wb_cyc;
  assign miso     = ss_s ? 1'b1 : tx[7];
  assign miso_oe  = !ss_s;

endmodule
